// File: rtl/sol32_exec_unit.sv
// sol32 registered execute stage: two-operand ALU, one-operand ALU and a condition
// comparator feeding Result/Flags/CondTrue registers with one cycle of latency.
module sol32_exec_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  input  logic        UnitSel,
  input  logic [3:0]  Op,
  input  logic [3:0]  Cond,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [31:0] CmpA,
  input  logic [31:0] CmpB,
  output logic        OutValid,
  output logic [31:0] Result,
  output logic [3:0]  Flags,
  output logic        CondTrue
);

  logic [31:0] res_s;
  logic        c_s;
  logic        v_s;
  logic        n_s;
  logic        z_s;
  logic        cond_s;
  logic [32:0] sum_s;
  logic [32:0] sll_s;
  logic [32:0] srl_s;
  logic [32:0] sra_s;
  logic [63:0] rol_s;
  logic [63:0] ror_s;
  logic [5:0]  clz_s;
  logic [5:0]  ctz_s;
  logic [5:0]  pop_s;
  logic [31:0] rev_s;
  logic [4:0]  amt_s;

  logic        out_valid_d, out_valid_q;
  logic [31:0] result_d, result_q;
  logic [3:0]  flags_d, flags_q;
  logic        cond_true_d, cond_true_q;

  // Bit-scan helpers shared by CLZ/CTZ/POPCNT/BITREV
  always_comb begin
    clz_s = 6'd32;
    ctz_s = 6'd32;
    pop_s = 6'd0;
    rev_s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      clz_s    = SrcA[i] ? 6'(31 - i) : clz_s;
      pop_s    = pop_s + 6'(SrcA[i]);
      rev_s[i] = SrcA[31 - i];
    end
    for (int i = 31; i >= 0; i--) begin
      ctz_s = SrcA[i] ? 6'(i) : ctz_s;
    end
  end

  // ALU datapath; the extra low/high bit on shifts captures the bit shifted out
  always_comb begin
    amt_s = SrcB[4:0];
    sll_s = {1'b0, SrcA} << amt_s;
    srl_s = {SrcA, 1'b0} >> amt_s;
    sra_s = $signed({SrcA, 1'b0}) >>> amt_s;
    rol_s = {SrcA, SrcA} << amt_s;
    ror_s = {SrcA, SrcA} >> amt_s;
    sum_s = 33'd0;
    res_s = 32'd0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    if (!UnitSel) begin
      case (Op)
        4'h0: begin
          sum_s = {1'b0, SrcA} + {1'b0, SrcB};
          res_s = sum_s[31:0];
          c_s   = sum_s[32];
          v_s   = (SrcA[31] == SrcB[31]) && (res_s[31] != SrcA[31]);
        end
        4'h1: begin
          sum_s = {1'b0, SrcA} + {1'b0, ~SrcB} + 33'd1;
          res_s = sum_s[31:0];
          c_s   = sum_s[32];
          v_s   = (SrcA[31] != SrcB[31]) && (res_s[31] != SrcA[31]);
        end
        4'h2: res_s = SrcA & SrcB;
        4'h3: res_s = SrcA | SrcB;
        4'h4: res_s = SrcA ^ SrcB;
        4'h5: res_s = ~(SrcA & SrcB);
        4'h6: res_s = ~(SrcA | SrcB);
        4'h7: res_s = ~(SrcA ^ SrcB);
        4'h8: res_s = SrcA & ~SrcB;
        4'h9: begin res_s = sll_s[31:0]; c_s = sll_s[32]; end
        4'hA: begin res_s = srl_s[32:1]; c_s = srl_s[0]; end
        4'hB: begin res_s = sra_s[32:1]; c_s = sra_s[0]; end
        4'hC: res_s = rol_s[63:32];
        4'hD: res_s = ror_s[31:0];
        4'hE: res_s = {31'd0, $signed(SrcA) < $signed(SrcB)};
        4'hF: res_s = {31'd0, SrcA < SrcB};
        default: res_s = 32'd0;
      endcase
    end else begin
      case (Op)
        4'h0: res_s = SrcA;
        4'h1: res_s = ~SrcA;
        4'h2: begin
          res_s = ~SrcA + 32'd1;
          c_s   = (SrcA != 32'd0);
          v_s   = (SrcA == 32'h8000_0000);
        end
        4'h3: begin
          sum_s = {1'b0, SrcA} + 33'd1;
          res_s = sum_s[31:0];
          c_s   = sum_s[32];
          v_s   = (SrcA == 32'h7FFF_FFFF);
        end
        4'h4: begin
          sum_s = {1'b0, SrcA} + 33'h0_FFFF_FFFF;
          res_s = sum_s[31:0];
          c_s   = sum_s[32];
          v_s   = (SrcA == 32'h8000_0000);
        end
        4'h5: res_s = {26'd0, clz_s};
        4'h6: res_s = {26'd0, ctz_s};
        4'h7: res_s = {26'd0, pop_s};
        4'h8: res_s = {SrcA[7:0], SrcA[15:8], SrcA[23:16], SrcA[31:24]};
        4'h9: res_s = rev_s;
        4'hA: res_s = {{24{SrcA[7]}}, SrcA[7:0]};
        4'hB: res_s = {{16{SrcA[15]}}, SrcA[15:0]};
        4'hC: res_s = {24'd0, SrcA[7:0]};
        4'hD: res_s = {16'd0, SrcA[15:0]};
        4'hE: begin
          res_s = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
          v_s   = (SrcA == 32'h8000_0000);
        end
        4'hF: begin res_s = {SrcA[30:0], 1'b0}; c_s = SrcA[31]; end
        default: res_s = 32'd0;
      endcase
    end
    n_s = res_s[31];
    z_s = (res_s == 32'd0);
  end

  // Condition evaluation against the comparator operands and the live ALU flags
  always_comb begin
    case (Cond)
      4'h0: cond_s = (CmpA == CmpB);
      4'h1: cond_s = (CmpA != CmpB);
      4'h2: cond_s = ($signed(CmpA) <  $signed(CmpB));
      4'h3: cond_s = ($signed(CmpA) >= $signed(CmpB));
      4'h4: cond_s = (CmpA <  CmpB);
      4'h5: cond_s = (CmpA >= CmpB);
      4'h6: cond_s = ($signed(CmpA) >  $signed(CmpB));
      4'h7: cond_s = ($signed(CmpA) <= $signed(CmpB));
      4'h8: cond_s = (CmpA >  CmpB);
      4'h9: cond_s = (CmpA <= CmpB);
      4'hA: cond_s = z_s;
      4'hB: cond_s = n_s;
      4'hC: cond_s = c_s;
      4'hD: cond_s = v_s;
      4'hE: cond_s = 1'b1;
      4'hF: cond_s = 1'b0;
      default: cond_s = 1'b0;
    endcase
  end

  // Next-state: load on a valid op, otherwise hold everything but OutValid
  always_comb begin
    out_valid_d = InValid;
    if (InValid) begin
      result_d    = res_s;
      flags_d     = {n_s, z_s, c_s, v_s};
      cond_true_d = cond_s;
    end else begin
      result_d    = result_q;
      flags_d     = flags_q;
      cond_true_d = cond_true_q;
    end
  end

  // Output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      flags_q     <= 4'd0;
      cond_true_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      cond_true_q <= cond_true_d;
    end
  end

  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign Flags    = flags_q;
  assign CondTrue = cond_true_q;

endmodule

// File: tb/tb_sol32_exec_unit.sv
// Scoreboard bench for sol32_exec_unit: directed ops push expected outputs,
// a negedge monitor pops and compares whenever OutValid is high.
module tb_sol32_exec_unit;

  logic        Clock;
  logic        Reset;
  logic        InValid;
  logic        UnitSel;
  logic [3:0]  Op;
  logic [3:0]  Cond;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] CmpA;
  logic [31:0] CmpB;
  logic        OutValid;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        CondTrue;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        cond;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int vec_id   = 0;

  sol32_exec_unit dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .UnitSel(UnitSel),
    .Op(Op), .Cond(Cond), .SrcA(SrcA), .SrcB(SrcB), .CmpA(CmpA), .CmpB(CmpB),
    .OutValid(OutValid), .Result(Result), .Flags(Flags), .CondTrue(CondTrue)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one op just after a rising edge and record what it should produce
  task automatic issue(input logic us, input logic [3:0] op, input logic [3:0] cd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ca, input logic [31:0] cb,
                       input logic [31:0] er, input logic [3:0] ef, input logic ec);
    exp_t e;
    @(posedge Clock);
    #1;
    InValid = 1'b1; UnitSel = us; Op = op; Cond = cd;
    SrcA = a; SrcB = b; CmpA = ca; CmpB = cb;
    e.id = vec_id; e.res = er; e.flags = ef; e.cond = ec;
    sb.push_back(e);
    vec_id++;
  endtask

  task automatic idle();
    @(posedge Clock);
    #1;
    InValid = 1'b0;
  endtask

  always @(negedge Clock) begin
    if (Reset && OutValid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got OutValid=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val($sformatf("vec%0d_result", e.id), Result, e.res);
        check_val($sformatf("vec%0d_flags", e.id), {28'd0, Flags}, {28'd0, e.flags});
        check_val($sformatf("vec%0d_cond", e.id), {31'd0, CondTrue}, {31'd0, e.cond});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; InValid = 1'b0; UnitSel = 1'b0; Op = 4'd0; Cond = 4'd0;
    SrcA = 32'd0; SrcB = 32'd0; CmpA = 32'd0; CmpB = 32'd0;
    #12;
    check_val("rst_valid", {31'd0, OutValid}, 32'd0);
    check_val("rst_result", Result, 32'd0);
    check_val("rst_flags", {28'd0, Flags}, 32'd0);
    check_val("rst_cond", {31'd0, CondTrue}, 32'd0);
    Reset = 1'b1;

    // alu2
    issue(1'b0, 4'h0, 4'hE, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'h8000_0000, 4'b1001, 1'b1);
    issue(1'b0, 4'h1, 4'hA, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b1);
    issue(1'b0, 4'hB, 4'hB, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000, 4'b1000, 1'b1);
    issue(1'b0, 4'h9, 4'hC, 32'h8000_0001, 32'd1, 32'd0, 32'd0, 32'h0000_0002, 4'b0010, 1'b1);
    issue(1'b0, 4'hA, 4'hC, 32'd3, 32'd0, 32'd0, 32'd0, 32'd3, 4'b0000, 1'b0);
    issue(1'b0, 4'hC, 4'hF, 32'h8000_0001, 32'd4, 32'd0, 32'd0, 32'h0000_0018, 4'b0000, 1'b0);
    issue(1'b0, 4'hE, 4'hE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 4'b0000, 1'b1);
    issue(1'b0, 4'hF, 4'hE, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 4'b0100, 1'b1);
    issue(1'b0, 4'h4, 4'hF, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 32'h0FF0_0FF0, 4'b0000, 1'b0);
    issue(1'b0, 4'h0, 4'hC, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b1);
    // alu1 with comparator conditions
    issue(1'b1, 4'h5, 4'h2, 32'h0001_0000, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd15, 4'b0000, 1'b1);
    issue(1'b1, 4'h5, 4'h4, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd32, 4'b0000, 1'b0);
    issue(1'b1, 4'h2, 4'hD, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 4'b1011, 1'b1);
    issue(1'b1, 4'hA, 4'h0, 32'h0000_0080, 32'd0, 32'd7, 32'd7, 32'hFFFF_FF80, 4'b1000, 1'b1);
    issue(1'b1, 4'h4, 4'h6, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4'b1000, 1'b1);
    issue(1'b1, 4'hE, 4'h8, 32'h8000_0000, 32'd0, 32'd3, 32'hFFFF_FFFE, 32'h8000_0000, 4'b1001, 1'b0);
    issue(1'b1, 4'h7, 4'hE, 32'hF000_000F, 32'd0, 32'd0, 32'd0, 32'd8, 4'b0000, 1'b1);
    issue(1'b1, 4'h8, 4'hF, 32'h1122_3344, 32'd0, 32'd0, 32'd0, 32'h4433_2211, 4'b0000, 1'b0);
    issue(1'b1, 4'h6, 4'hE, 32'h0000_0100, 32'd0, 32'd0, 32'd0, 32'd8, 4'b0000, 1'b1);
    issue(1'b1, 4'h3, 4'hD, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 4'b1001, 1'b1);

    // Hold: idle cycles with fresh operands must not disturb the held outputs
    idle();
    SrcA = 32'h1234_5678; SrcB = 32'h1; UnitSel = 1'b0; Op = 4'h0;
    @(negedge Clock);
    @(negedge Clock);
    check_val("hold_valid", {31'd0, OutValid}, 32'd0);
    check_val("hold_result", Result, 32'h8000_0000);
    check_val("hold_flags", {28'd0, Flags}, 32'h9);

    // Reset mid-op: a valid op is pending when reset drops between edges
    @(posedge Clock);
    #1;
    InValid = 1'b1; UnitSel = 1'b1; Op = 4'h0; SrcA = 32'hDEAD_BEEF; Cond = 4'hE;
    #2;
    Reset = 1'b0;
    #1;
    check_val("midrst_valid", {31'd0, OutValid}, 32'd0);
    check_val("midrst_result", Result, 32'd0);
    check_val("midrst_flags", {28'd0, Flags}, 32'd0);
    check_val("midrst_cond", {31'd0, CondTrue}, 32'd0);
    @(posedge Clock);
    #1;
    check_val("rsthold_valid", {31'd0, OutValid}, 32'd0);
    check_val("rsthold_result", Result, 32'd0);
    InValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;

    // Recovery after reset
    issue(1'b1, 4'hB, 4'hB, 32'h0000_8001, 32'd0, 32'd0, 32'd0, 32'hFFFF_8001, 4'b1000, 1'b1);
    idle();
    repeat (3) @(posedge Clock);
    #1;
    check_val("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
